// File: rtl/bus_responder_pkg.sv
// Shared bus types and defaults for the ibus/dbus memory responder.
// Request/response structs follow the core's valid/addr_ok/data_ok handshake.
package bus_responder_pkg;

  localparam logic [63:0] RESP_BASE_ADDR   = 64'h8000_0000;
  localparam int          RESP_DEPTH_WORDS = 4096;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
  typedef enum logic {PORT_I, PORT_D} resp_port_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // A store may not touch more byte lanes than its access size covers.
  function automatic logic strobe_fits(input logic [7:0] strobe, input logic [2:0] size);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(strobe[i]);
    return ones <= (1 << size);
  endfunction

endpackage

// File: rtl/bus_responder_ram.sv
// Backing store: single-port 64-bit RAM, byte write enables, combinational read.
// Contents survive reset.
module resp_ram
  import bus_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = RESP_DEPTH_WORDS,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for ibus and dbus: round-robin arbitration, one
// transaction in flight, fixed accept-to-data_ok latency.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = RESP_BASE_ADDR,
  parameter int          DEPTH_WORDS = RESP_DEPTH_WORDS,
  parameter int          LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("bus_responder: LATENCY must be within 1..15");
  end

  resp_state_t state;
  resp_port_t  last_grant;
  resp_port_t  port;
  logic [3:0]  cnt;
  logic [15:0] err_cnt;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  strobe_q;

  logic        grant_i, grant_d;
  logic        resp_i, resp_d;
  logic        in_range;
  logic [63:0] offset;
  logic [63:0] rdata;
  logic [7:0]  we;

  // Grants are only offered from IDLE, so RESP can never overlap a new accept.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset && state == IDLE) begin
      grant_d = dreq.valid && (!ireq.valid || last_grant == PORT_I);
      grant_i = ireq.valid && !grant_d;
    end
  end

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
  assign resp_i   = !reset && state == RESP && port == PORT_I;
  assign resp_d   = !reset && state == RESP && port == PORT_D;
  assign we       = (resp_d && in_range) ? strobe_q : 8'h00;

  resp_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (offset[AW+2:3]),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_I;
      cnt        <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            if (grant_d) begin
              port     <= PORT_D;
              addr_q   <= dreq.addr;
              strobe_q <= dreq.strobe;
            end else begin
              port     <= PORT_I;
              addr_q   <= ireq.addr;
              strobe_q <= 8'h00;
            end
            wdata_q <= dreq.data;
            cnt     <= CNT_INIT;
            if (LATENCY == 1) state <= RESP;
            else              state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          last_grant <= port;
          state      <= IDLE;
          if (!in_range && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is taken from RAM in RESP, so an earlier write is already visible.
  always_comb begin
    iresp         = '0;
    dresp         = '0;
    iresp.addr_ok = grant_i;
    dresp.addr_ok = grant_d;
    iresp.data_ok = resp_i;
    dresp.data_ok = resp_d;
    if (resp_i && in_range) iresp.data = addr_q[2] ? rdata[63:32] : rdata[31:0];
    if (resp_d && in_range && strobe_q == 8'h00) dresp.data = rdata;
  end

  assert property (@(posedge clk) disable iff (reset)
                   grant_d |-> strobe_fits(dreq.strobe, dreq.size));

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: transaction-level model with per-cycle comparison,
// directed scenarios, and randomized two-port traffic.
module tb_bus_responder;
  import bus_responder_pkg::*;

  localparam int          L    = 2;
  localparam int          DW   = 4096;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq,  ireq1;
  ibus_resp_t iresp, iresp1;
  dbus_req_t  dreq,  dreq1;
  dbus_resp_t dresp, dresp1;

  always #5 clk = ~clk;

  bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .LATENCY(L), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .dreq(dreq), .dresp(dresp));

  bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset), .ireq(ireq1), .iresp(iresp1), .dreq(dreq1), .dresp(dresp1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: word store plus "busy until cycle" bookkeeping.
  logic [63:0] mmem [int];
  bit          m_busy = 0;
  int          m_due  = 0;
  bit          m_port = 0;   // 1 = dbus
  bit          m_last = 0;   // 1 = dbus served last
  logic [63:0] m_addr, m_wd;
  logic [7:0]  m_st;
  int          m_err  = 0;
  int          cyc    = 0;

  bit          i_acc = 0, d_acc = 0, i_dok = 0, d_dok = 0;
  logic [31:0] i_dat;
  logic [63:0] d_dat;

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DW));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  always @(negedge clk) begin
    bit          e_ia, e_da, e_io, e_do;
    logic [31:0] e_id;
    logic [63:0] e_dd, w;
    e_ia = 0; e_da = 0; e_io = 0; e_do = 0; e_id = '0; e_dd = '0; w = '0;
    cyc++;
    if (!reset) begin
      if (m_busy && cyc == m_due) begin
        if (in_rng(m_addr)) w = mmem[widx(m_addr)];
        if (m_port) begin
          e_do = 1;
          if (m_st == 8'h00) e_dd = w;
        end else begin
          e_io = 1;
          e_id = m_addr[2] ? w[63:32] : w[31:0];
        end
      end else if (!m_busy) begin
        e_da = dreq.valid && (!ireq.valid || !m_last);
        e_ia = ireq.valid && !e_da;
      end
    end
    check("iresp.addr_ok", 64'(iresp.addr_ok), 64'(e_ia));
    check("dresp.addr_ok", 64'(dresp.addr_ok), 64'(e_da));
    check("iresp.data_ok", 64'(iresp.data_ok), 64'(e_io));
    check("dresp.data_ok", 64'(dresp.data_ok), 64'(e_do));
    check("iresp.data", 64'(iresp.data), 64'(e_id));
    check("dresp.data", dresp.data, e_dd);
    check("err_cnt", 64'(dut.err_cnt), 64'(m_err));
    i_acc = iresp.addr_ok; d_acc = dresp.addr_ok;
    i_dok = iresp.data_ok; d_dok = dresp.data_ok;
    i_dat = iresp.data;    d_dat = dresp.data;
    if (reset) begin
      m_busy = 0; m_last = 0; m_err = 0;
    end else if (m_busy && cyc == m_due) begin
      if (!in_rng(m_addr)) m_err++;
      else if (m_port) begin
        w = mmem[widx(m_addr)];
        for (int i = 0; i < 8; i++) if (m_st[i]) w[8*i +: 8] = m_wd[8*i +: 8];
        mmem[widx(m_addr)] = w;
      end
      m_last = m_port;
      m_busy = 0;
    end else if (e_da || e_ia) begin
      m_busy = 1;
      m_due  = cyc + L;
      m_port = e_da;
      m_addr = e_da ? dreq.addr : ireq.addr;
      m_st   = e_da ? dreq.strobe : 8'h00;
      m_wd   = dreq.data;
    end
  end

  // One complete transaction on one port of dut; returns data and accept-to-data_ok cycles.
  task automatic txn(input bit isd, input logic [63:0] a, input logic [7:0] st,
                     input logic [63:0] d, output logic [63:0] rd, output int lat);
    int t, acc_c;
    @(posedge clk); #1;
    if (isd) begin
      dreq.valid = 1; dreq.addr = a; dreq.strobe = st; dreq.data = d; dreq.size = 3'd3;
    end else begin
      ireq.valid = 1; ireq.addr = a;
    end
    t = 0;
    do begin @(posedge clk); t++; end while (!(isd ? d_acc : i_acc) && t < 20);
    check("txn_accepted", 64'(isd ? d_acc : i_acc), 64'd1);
    acc_c = cyc;
    #1;
    dreq.valid = 0; ireq.valid = 0;
    t = 0;
    do begin @(posedge clk); t++; end while (!(isd ? d_dok : i_dok) && t < 20);
    check("txn_data_ok", 64'(isd ? d_dok : i_dok), 64'd1);
    lat = cyc - acc_c;
    rd  = isd ? d_dat : {32'h0, i_dat};
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 64'd8;
      1:       return BASE + 64'(8 * DW) + 64'(8 * $urandom_range(0, 3));
      default: return BASE + 64'(8 * $urandom_range(0, 15)) + 64'(4 * $urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, v;
    int          lat, t, dok_seen;
    bit          order[$];

    ireq = '0; dreq = '0; ireq1 = '0; dreq1 = '0;
    dreq.size = 3'd3; dreq1.size = 3'd3;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_iresp", 64'(iresp), 64'd0);
    check("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    check("rst_dresp_data", dresp.data, 64'd0);

    // Preload words 0..15 through the dbus.
    for (int k = 0; k < 16; k++) begin
      if (k == 0)      v = 64'h1111_2222_3333_4444;
      else if (k == 2) v = 64'hFFFF_FFFF_FFFF_FFFF;
      else             v = {32'hA000_0000 + 32'(k), 32'h0B00_0000 + 32'(k)};
      txn(1, BASE + 64'(8 * k), 8'hFF, v, rd, lat);
      if (k == 0) check("write_data_zero", rd, 64'd0);
    end

    // Partial write then read-back of the same word.
    txn(1, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_5555_5555, rd, lat);
    txn(1, 64'h8000_0010, 8'h00, 64'h0, rd, lat);
    check("partial_write_read", rd, 64'hFFFF_FFFF_5555_5555);

    // ibus upper-half fetch.
    txn(0, 64'h8000_0004, 8'h00, 64'h0, rd, lat);
    check("ifetch_hi_data", rd, 64'h1111_2222);
    check("ifetch_latency", 64'(lat), 64'd2);
    txn(0, 64'h8000_0028, 8'h00, 64'h0, rd, lat);
    check("ifetch_lo_data", rd, 64'h0B00_0005);

    // Both ports requesting continuously: grants alternate starting with dbus.
    @(posedge clk); #1;
    ireq.valid = 1; ireq.addr = BASE + 64'd4;
    dreq.valid = 1; dreq.addr = BASE + 64'd8; dreq.strobe = 8'h00;
    t = 0;
    while (order.size() < 6 && t < 60) begin
      @(posedge clk); t++;
      if (d_acc) order.push_back(1'b1);
      if (i_acc) order.push_back(1'b0);
    end
    #1 ireq.valid = 0; dreq.valid = 0;
    check("contend_count", 64'(order.size()), 64'd6);
    for (int k = 0; k < order.size(); k++)
      check($sformatf("contend_grant%0d", k), 64'(order[k]), 64'((k % 2) == 0));
    repeat (4) @(posedge clk);

    // Out-of-range accesses after a fresh reset.
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    txn(1, 64'h7FFF_FFF8, 8'h00, 64'h0, rd, lat);
    check("oor_read_data", rd, 64'd0);
    check("oor_read_latency", 64'(lat), 64'd2);
    txn(1, 64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, lat);
    check("oor_write_latency", 64'(lat), 64'd2);
    @(posedge clk); #1;
    check("oor_err_cnt", 64'(dut.err_cnt), 64'd2);
    txn(1, BASE, 8'h00, 64'h0, rd, lat);
    check("oor_word0_intact", rd, 64'h1111_2222_3333_4444);

    // Reset while a full-word write waits for its response.
    @(posedge clk); #1;
    dreq.valid = 1; dreq.addr = BASE + 64'd40; dreq.strobe = 8'hFF; dreq.data = 64'hDEAD_BEEF_0000_0000;
    t = 0;
    do begin @(posedge clk); t++; end while (!d_acc && t < 20);
    check("rstwait_accept", 64'(d_acc), 64'd1);
    #1 dreq.valid = 0; reset = 1;
    @(posedge clk); #1 reset = 0;
    dok_seen = 0;
    repeat (6) begin @(posedge clk); if (d_dok) dok_seen++; end
    check("rstwait_no_data_ok", 64'(dok_seen), 64'd0);
    txn(1, BASE + 64'd40, 8'h00, 64'h0, rd, lat);
    check("rstwait_word_intact", rd, 64'hA000_0005_0B00_0005);
    check("rstwait_next_latency", 64'(lat), 64'd2);

    // Randomized traffic on both ports, held until accepted.
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (!ireq.valid || i_acc) begin
        ireq.valid = ($urandom_range(0, 2) != 0);
        ireq.addr  = rand_addr();
      end
      if (!dreq.valid || d_acc) begin
        dreq.valid  = ($urandom_range(0, 2) != 0);
        dreq.addr   = rand_addr();
        dreq.strobe = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
        dreq.data   = {$urandom, $urandom};
      end
    end
    @(posedge clk); #1 ireq.valid = 0; dreq.valid = 0;
    repeat (6) @(posedge clk);

    // LATENCY=1 instance: write, then a held read request served every other cycle.
    @(posedge clk); #1;
    dreq1.valid = 1; dreq1.addr = BASE + 64'd8; dreq1.strobe = 8'hFF; dreq1.data = 64'hC0FF_EE00_1234_5678;
    @(negedge clk);
    check("l1_write_addr_ok", 64'(dresp1.addr_ok), 64'd1);
    @(posedge clk); #1 dreq1.strobe = 8'h00;
    @(negedge clk);
    check("l1_write_data_ok", 64'(dresp1.data_ok), 64'd1);
    check("l1_write_no_addr_ok", 64'(dresp1.addr_ok), 64'd0);
    check("l1_write_data_zero", dresp1.data, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("l1_addr_ok%0d", k), 64'(dresp1.addr_ok), 64'((k % 2) == 0));
      check($sformatf("l1_data_ok%0d", k), 64'(dresp1.data_ok), 64'((k % 2) == 1));
      check($sformatf("l1_data%0d", k), dresp1.data,
            (k % 2 == 1) ? 64'hC0FF_EE00_1234_5678 : 64'd0);
    end
    check("l1_ibus_idle", 64'(iresp1), 64'd0);
    #1 dreq1.valid = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
